// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared encodings for the traffic sequencer
// Purpose: state encoding, duration-selector codes, lamp patterns and the
//          state-to-interval mapping shared by the sequencer and its bench.
// Ports:   none (package).
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN     = 3'd0,
    MAIN_GREEN2    = 3'd1,
    MAIN_YELLOW    = 3'd2,
    WALK           = 3'd3,
    SIDE_GREEN     = 3'd4,
    SIDE_GREEN_EXT = 3'd5,
    SIDE_YELLOW    = 3'd6
  } state_e;

  localparam logic [1:0] INT_BASE   = 2'b00;
  localparam logic [1:0] INT_EXT    = 2'b01;
  localparam logic [1:0] INT_YELLOW = 2'b10;

  // Lamp vectors are {R,Y,G}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Duration selector for a state being entered; only MAIN_GREEN2 depends
  // on the side-street sensor.
  function automatic logic [1:0] interval_for(input state_e s, input logic sensor);
    case (s)
      MAIN_GREEN2:                interval_for = sensor ? INT_EXT : INT_BASE;
      MAIN_YELLOW, SIDE_YELLOW:   interval_for = INT_YELLOW;
      WALK, SIDE_GREEN_EXT:       interval_for = INT_EXT;
      default:                    interval_for = INT_BASE;
    endcase
  endfunction

endpackage

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - load/decrement/expire tick counter
// Purpose: holds the ticks left in the current state.
// Ports:   clk, resetn (sync, active-low)
//          load    - load cycle: count takes max(value,1), tick ignored
//          tick    - decrement enable
//          value   - duration to load
//          expired - tick seen with count = 1 (state ends on this edge)
//          count   - current counter value
module interval_timer
  import traffic_pkg::*;
#(
  parameter int VALUE_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               tick,
  input  logic [VALUE_W-1:0] value,
  output logic               expired,
  output logic [VALUE_W-1:0] count
);

  localparam logic [VALUE_W-1:0] ONE = 1;

  logic [VALUE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      // A zero duration is stretched to one tick so every state is visible.
      count_d = (value == '0) ? ONE : value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = tick && !load && (count_q == ONE);
  assign count   = count_q;

endmodule

// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - main/side/pedestrian traffic light sequencer
// Purpose: seven-state light FSM with walk latch; durations come from an
//          external time-parameter store addressed by interval.
// Ports:   clk, reset (sync, active-low)
//          tick, sensor, walk_Request, sync_Reprogram - control inputs
//          time_Value  - duration for the current interval (combinational)
//          interval    - registered duration selector
//          main_Light, side_Light ({R,Y,G}), walk_Light - lamps
//          remaining   - ticks left, 0 during the load cycle
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int VALUE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               sensor,
  input  logic               walk_Request,
  input  logic               sync_Reprogram,
  input  logic [VALUE_W-1:0] time_Value,
  output logic [1:0]         interval,
  output logic [2:0]         main_Light,
  output logic [2:0]         side_Light,
  output logic               walk_Light,
  output logic [VALUE_W-1:0] remaining
);

  state_e      state_q, state_d, state_next;
  logic        load_q, load_d;
  logic        walk_q, walk_d;
  logic [1:0]  interval_q, interval_d;
  logic        expired;
  logic [VALUE_W-1:0] count;

  interval_timer #(.VALUE_W(VALUE_W)) u_timer (
    .clk     (clk),
    .resetn  (reset),
    .load    (load_q),
    .tick    (tick),
    .value   (time_Value),
    .expired (expired),
    .count   (count)
  );

  always_comb begin
    case (state_q)
      MAIN_GREEN:     state_next = MAIN_GREEN2;
      MAIN_GREEN2:    state_next = MAIN_YELLOW;
      MAIN_YELLOW:    state_next = walk_q ? WALK : SIDE_GREEN;
      WALK:           state_next = SIDE_GREEN;
      SIDE_GREEN:     state_next = sensor ? SIDE_GREEN_EXT : SIDE_YELLOW;
      SIDE_GREEN_EXT: state_next = SIDE_YELLOW;
      default:        state_next = MAIN_GREEN;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load_d     = 1'b0;
    interval_d = interval_q;
    walk_d     = walk_q | walk_Request;
    if (sync_Reprogram) begin
      // Restart keeps any pending pedestrian request.
      state_d    = MAIN_GREEN;
      interval_d = INT_BASE;
      load_d     = 1'b1;
    end else if (expired) begin
      state_d    = state_next;
      interval_d = interval_for(state_next, sensor);
      load_d     = 1'b1;
      // Entering WALK serves the request; a new press on this edge is lost.
      if (state_next == WALK) begin
        walk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= MAIN_GREEN;
      load_q     <= 1'b1;
      walk_q     <= 1'b0;
      interval_q <= INT_BASE;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      walk_q     <= walk_d;
      interval_q <= interval_d;
    end
  end

  always_comb begin
    main_Light = RED;
    side_Light = RED;
    walk_Light = 1'b0;
    case (state_q)
      MAIN_GREEN, MAIN_GREEN2:    main_Light = GRN;
      MAIN_YELLOW:                main_Light = YEL;
      SIDE_GREEN, SIDE_GREEN_EXT: side_Light = GRN;
      SIDE_YELLOW:                side_Light = YEL;
      WALK:                       walk_Light = 1'b1;
      default:                    main_Light = RED;
    endcase
  end

  assign interval  = interval_q;
  // The counter still holds the previous state's residue while loading.
  assign remaining = load_q ? '0 : count;

endmodule

// File: doc/traffic_sequencer.md
TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk, and reset, where reset = 0 at a rising clk edge resets the block.
REQ-002 Parameter VALUE_W SHALL default to 4 and set the width of time_Value and remaining.
REQ-003 Port clk: input, 1 bit, rising-edge system clock.
REQ-004 Port reset: input, 1 bit, synchronous active-low reset.
REQ-005 Port tick: input, 1 bit, one-cycle 1 Hz enable; counting advances only on cycles where tick = 1.
REQ-006 Port sensor: input, 1 bit, side-street vehicle present.
REQ-007 Port walk_Request: input, 1 bit, pedestrian button; a one-cycle pulse is sufficient.
REQ-008 Port sync_Reprogram: input, 1 bit, parameters reprogrammed; the sequence restarts.
REQ-009 Port time_Value: input, VALUE_W bits, duration in ticks returned by the time-parameter store for the current interval; valid combinationally.
REQ-010 Port interval: output, 2 bits, duration selector to the time-parameter store: 00 = base, 01 = extended, 10 = yellow.
REQ-011 Port main_Light: output, 3 bits, main-street lamps {R,Y,G}; exactly one bit is set.
REQ-012 Port side_Light: output, 3 bits, side-street lamps {R,Y,G}; exactly one bit is set.
REQ-013 Port walk_Light: output, 1 bit, pedestrian walk lamp.
REQ-014 Port remaining: output, VALUE_W bits, ticks left in the current state.

Function
REQ-015 The states and their intervals SHALL be:
- MAIN_GREEN: base
- MAIN_GREEN2: extended if sensor = 1, else base
- MAIN_YELLOW: yellow
- WALK: extended
- SIDE_GREEN: base
- SIDE_GREEN_EXT: extended
- SIDE_YELLOW: yellow
REQ-016 For MAIN_GREEN2, sensor SHALL be sampled in the cycle the state is entered.
REQ-017 On expiry, transitions SHALL be:
- MAIN_GREEN -> MAIN_GREEN2
- MAIN_GREEN2 -> MAIN_YELLOW
- MAIN_YELLOW -> WALK if the walk latch is set, else SIDE_GREEN
- WALK -> SIDE_GREEN
- SIDE_GREEN -> SIDE_GREEN_EXT if sensor = 1 at expiry, else SIDE_YELLOW
- SIDE_GREEN_EXT -> SIDE_YELLOW
- SIDE_YELLOW -> MAIN_GREEN
REQ-018 Lamps SHALL be Moore outputs of the state register:
- Main street is G in MAIN_GREEN and MAIN_GREEN2, Y in MAIN_YELLOW, and R in every other state.
- Side street is G in SIDE_GREEN and SIDE_GREEN_EXT, Y in SIDE_YELLOW, and R in every other state.
- walk_Light = 1 only in WALK, where both streets show R (100).
REQ-019 interval SHALL be registered and updated in the same edge as the state register.
REQ-020 Each state entry SHALL begin with one load cycle in which the counter takes max(time_Value, 1); a tick in the load cycle is ignored.
REQ-021 After the load cycle, the counter SHALL decrement on each tick.
REQ-022 A tick with counter = 1 SHALL cause the state change at that same edge, so each state lasts exactly max(time_Value, 1) ticks plus one load cycle.
REQ-023 remaining SHALL equal the counter value, and 0 during the load cycle.
REQ-024 The walk latch SHALL be set by walk_Request = 1 in any cycle, and cleared on the edge that enters WALK; clear wins if walk_Request is high on that edge.
REQ-025 sync_Reprogram = 1 SHALL force MAIN_GREEN with interval = 00 and a load cycle pending on the next edge, from any state, without clearing the walk latch.
REQ-026 Priority SHALL be: reset > sync_Reprogram > expiry transition.
REQ-027 time_Value changes after the load cycle SHALL NOT affect the running count.

Reset
REQ-028 While reset = 0 at an edge, the block SHALL load:
- state = MAIN_GREEN, load pending, counter = 0, walk latch = 0
- interval = 00
- main_Light = 001, side_Light = 100, walk_Light = 0, remaining = 0
REQ-029 A reset in any state, including WALK and mid-count, SHALL take effect at the next edge with no partial state retained.

Structure
REQ-030 A shared package traffic_pkg SHALL hold the state encoding, the interval codes (INT_BASE = 00, INT_EXT = 01, INT_YELLOW = 10) and the lamp encodings (RED = 100, YEL = 010, GRN = 001).
REQ-031 The load/decrement/expire counter SHALL be a sub-module, interval_timer, with inputs load, tick and value and outputs expired and count.
REQ-032 The FSM and the walk latch SHALL reside in traffic_sequencer.

Verification
REQ-033 The bench SHALL model the store as base = 6, ext = 3, yellow = 2, with tick high every 4th cycle, and cover:
- Reset: hold reset = 0 for 3 cycles -> MAIN_GREEN, interval = 00, main = 001, side = 100, walk = 0, remaining = 0.
- Base cycle: sensor = 0, no walk -> states last MAIN_GREEN 6, MAIN_GREEN2 6, MAIN_YELLOW 2, SIDE_GREEN 6, SIDE_YELLOW 2 ticks, then return to MAIN_GREEN; interval sequence 00, 00, 10, 00, 10.
- Sensor: sensor = 1 -> MAIN_GREEN2 lasts 3 ticks with interval 01, and SIDE_GREEN_EXT lasts 3 ticks.
- Walk: a one-cycle walk_Request during MAIN_GREEN -> WALK after MAIN_YELLOW for 3 ticks, walk_Light = 1, main = side = 100, latch clear afterwards; a request on the WALK-entry edge is dropped.
- Reprogram: sync_Reprogram pulse mid SIDE_GREEN with remaining = 4 -> next edge MAIN_GREEN, interval = 00, then one load cycle and remaining = 6.
- Boundaries: time_Value = 0 -> state lasts 1 tick; tick in the load cycle is ignored; reset = 0 mid-WALK -> the REQ-028 values on the next edge.
